// File: rtl/cache_refill_ctrl_if.sv
// AXI master-side bus between the refill engine and the interconnect.
// Only the channels the engine uses are carried; BRESP and RRESP are not.
interface cache_refill_ctrl_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rlast,
    input  rready
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss engine: optional victim write-back burst, then a line refill burst,
// followed by a one-cycle refresh of the tag/valid/LRU state.
//  state | meaning
//  IDLE  | waiting for a miss; latches addresses and victim way
//  WB_AW | victim write address phase
//  WB_W  | streaming victim words out of the data array
//  WB_B  | waiting for the write response
//  RD_AR | refill read address phase
//  RD_R  | writing refill words into the data array
//  DONE  | one-cycle refresh pulse to the tag block
module cache_refill_ctrl #(
  parameter int LINE_WORDS = 16,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss,
  input  logic             write_back,
  input  logic [31:0]      axi_raddr,
  input  logic [31:0]      axi_waddr,
  input  logic             lru,
  output logic             busy,
  output logic             refresh,
  output logic             way,
  output logic [CNT_W-1:0] wb_idx,
  input  logic [31:0]      wb_rdata,
  output logic             refill_we,
  output logic [CNT_W-1:0] refill_idx,
  output logic [31:0]      refill_wdata,
  cache_refill_ctrl_if.master axi
);

  typedef enum logic [2:0] {IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      raddr_q, waddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      way     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && miss) begin
        raddr_q <= axi_raddr;
        waddr_q <= axi_waddr;
        way     <= lru;
      end
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    busy        = (state != IDLE);
    refresh     = 1'b0;
    refill_we   = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    case (state)
      IDLE: begin
        if (miss) begin
          cnt_d   = '0;
          state_d = write_back ? WB_AW : RD_AR;
        end
      end
      WB_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_d = WB_W;
      end
      WB_W: begin
        axi.wvalid = 1'b1;
        axi.wlast  = (cnt == LAST_IDX);
        if (axi.wready) begin
          cnt_d = cnt + 1'b1;
          if (cnt == LAST_IDX) state_d = WB_B;
        end
      end
      WB_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = RD_AR;
      end
      RD_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = RD_R;
      end
      RD_R: begin
        axi.rready = 1'b1;
        // termination is by beat count; rlast is deliberately not trusted
        if (axi.rvalid) begin
          refill_we = 1'b1;
          cnt_d     = cnt + 1'b1;
          if (cnt == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        refresh = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_idx       = cnt;
  assign refill_idx   = cnt;
  assign refill_wdata = axi.rdata;

  assign axi.awaddr  = waddr_q;
  assign axi.awlen   = 8'(LINE_WORDS - 1);
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.wdata   = wb_rdata;
  assign axi.wstrb   = 4'hF;
  assign axi.araddr  = raddr_q;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a random-stall AXI slave, a data-array model,
// expected-transaction queues filled at miss issue and drained by a bus monitor.
module tb_cache_refill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        miss = 1'b0, write_back = 1'b0, lru = 1'b0;
  logic [31:0] axi_raddr = '0, axi_waddr = '0;
  logic        busy, refresh, way, refill_we;
  logic [3:0]  wb_idx, refill_idx;
  logic [31:0] wb_rdata, refill_wdata;

  cache_refill_ctrl_if bus();

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
    .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .lru(lru),
    .busy(busy), .refresh(refresh), .way(way), .wb_idx(wb_idx), .wb_rdata(wb_rdata),
    .refill_we(refill_we), .refill_idx(refill_idx), .refill_wdata(refill_wdata),
    .axi(bus)
  );

  logic [31:0] mem [2][16];
  logic [31:0] cur_line [16];
  assign wb_rdata = mem[way][wb_idx];

  int errors = 0, checks = 0;
  bit rand_bp = 1'b0;

  typedef struct {logic [31:0] data; logic last; logic [3:0] idx;} wexp_t;
  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  wexp_t       exp_w[$];
  logic [35:0] exp_r[$];
  logic        exp_ref[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI slave: samples handshakes mid-cycle, drives new ready/valid just after the edge
  bit aw_f, w_f, wl_f, b_f, ar_f, r_f, r_act, b_pend;
  int rbeat;
  initial begin
    r_act = 0; b_pend = 0; rbeat = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0;
    bus.rvalid = 0; bus.rdata = '0; bus.rlast = 0;
    forever begin
      @(negedge clk);
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      wl_f = bus.wlast;
      b_f  = bus.bvalid && bus.bready;
      ar_f = bus.arvalid && bus.arready;
      r_f  = bus.rvalid && bus.rready;
      @(posedge clk);
      #1;
      if (rst) begin
        r_act = 0; b_pend = 0; rbeat = 0;
      end else begin
        if (ar_f) begin r_act = 1; rbeat = 0; end
        if (r_f) begin
          rbeat++;
          if (rbeat == 16) r_act = 0;
        end
        if (w_f && wl_f) b_pend = 1;
        if (b_f) b_pend = 0;
      end
      bus.awready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.arready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bvalid  = b_pend && (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.rvalid  = r_act && (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.rdata   = r_act ? cur_line[rbeat] : $urandom;
      bus.rlast   = r_act && (rbeat == 15);
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  logic        p_aw = 0, p_w = 0, p_ar = 0, b_wait = 0;
  logic [31:0] p_awaddr, p_araddr, p_wdata;
  logic [3:0]  p_widx;
  initial begin
    wexp_t we;
    logic [35:0] re;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_aw = 0; p_w = 0; p_ar = 0; b_wait = 0;
      end else begin
        if (p_aw) chk("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awaddr});
        if (p_ar) chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_araddr});
        if (p_w)  chk("w_hold", {bus.wvalid, wb_idx, bus.wdata}, {1'b1, p_widx, p_wdata});
        if (bus.awvalid && bus.awready) begin
          chk("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) chk("awaddr", bus.awaddr, exp_aw.pop_front());
          chk("aw_attr", {bus.awlen, bus.awsize, bus.awburst}, {8'd15, 3'd2, 2'b01});
        end
        if (bus.wvalid && bus.wready) begin
          chk("w_expected", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) begin
            we = exp_w.pop_front();
            chk("w_beat", {bus.wdata, bus.wlast, wb_idx}, {we.data, we.last, we.idx});
          end
          chk("wstrb", bus.wstrb, 4'hF);
          if (bus.wlast) b_wait = 1;
        end
        if (bus.bvalid && bus.bready) begin
          chk("b_expected", b_wait, 1);
          b_wait = 0;
        end
        if (bus.arvalid && bus.arready) begin
          chk("ar_order", {exp_aw.size() == 0, exp_w.size() == 0, !b_wait}, 3'b111);
          chk("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) chk("araddr", bus.araddr, exp_ar.pop_front());
          chk("ar_attr", {bus.arlen, bus.arsize, bus.arburst}, {8'd15, 3'd2, 2'b01});
        end
        if (refill_we) begin
          chk("refill_expected", exp_r.size() != 0, 1);
          if (exp_r.size() != 0) begin
            re = exp_r.pop_front();
            chk("refill_word", {refill_idx, refill_wdata}, re);
          end
        end
        if (refresh) begin
          chk("refresh_expected", exp_ref.size() != 0, 1);
          if (exp_ref.size() != 0) chk("refresh_way", way, exp_ref.pop_front());
          chk("refresh_after_beats", exp_r.size(), 0);
        end
        p_aw = bus.awvalid && !bus.awready; p_awaddr = bus.awaddr;
        p_ar = bus.arvalid && !bus.arready; p_araddr = bus.araddr;
        p_w  = bus.wvalid && !bus.wready;   p_wdata = bus.wdata; p_widx = wb_idx;
      end
    end
  end

  task automatic start_miss(input logic [31:0] ra, input logic [31:0] wa,
                            input logic wbv, input logic lv, input bit fixed);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      t = fixed ? 32'hA0 + 32'(i) : $urandom;
      cur_line[i] = t;
      exp_r.push_back({4'(i), t});
    end
    if (wbv) begin
      exp_aw.push_back(wa);
      for (int i = 0; i < 16; i++) exp_w.push_back('{mem[lv][i], (i == 15), 4'(i)});
    end
    exp_ar.push_back(ra);
    exp_ref.push_back(lv);
    miss = 1; write_back = wbv; axi_raddr = ra; axi_waddr = wa; lru = lv;
  endtask

  task automatic wait_refresh(output int cyc, output bit c1);
    cyc = 0; c1 = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) c1 = busy && (bus.arvalid || bus.awvalid);
    end while (!refresh && cyc < 3000);
    chk("refresh_seen", refresh, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk("idle_reached", busy, 0);
  endtask

  function automatic logic [31:0] rand_line();
    logic [31:0] t;
    t = $urandom;
    return {t[31:6], 6'b0};
  endfunction

  initial begin
    int cyc, k;
    bit c1;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++) mem[w][i] = $urandom;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, refresh, way, refill_we, bus.awvalid, bus.wvalid,
                          bus.bready, bus.arvalid, bus.rready, bus.wlast}, 0);
    chk("reset_addr", {bus.awaddr, bus.araddr}, 0);
    rst = 0;
    @(negedge clk);

    // clean miss, zero wait states
    start_miss(32'h1FC0_0040, 32'h0, 1'b0, 1'b0, 1'b1);
    wait_refresh(cyc, c1);
    miss = 0;
    chk("clean_first_cycle", c1, 1);
    chk("clean_refresh_cycle", cyc, 18);
    @(negedge clk);
    chk("clean_idle_cycle19", busy, 0);

    // dirty miss with victim in way 1
    start_miss(32'h0000_2000, 32'h0000_1280, 1'b1, 1'b1, 1'b0);
    wait_refresh(cyc, c1);
    miss = 0; write_back = 0;
    chk("dirty_first_cycle", c1, 1);
    chk("dirty_refresh_cycle", cyc, 36);
    wait_idle();

    // write_back alone must not start anything
    write_back = 1;
    repeat (5) begin
      @(negedge clk);
      chk("wb_without_miss", {busy, bus.awvalid, bus.arvalid, bus.wvalid}, 0);
    end
    write_back = 0;

    // reset during refill beat 7
    start_miss(rand_line(), rand_line(), 1'b0, 1'b1, 1'b0);
    k = 0;
    while (!(refill_we && refill_idx == 4'd7) && k < 500) begin @(negedge clk); k++; end
    chk("beat7_reached", {refill_we, refill_idx}, {1'b1, 4'd7});
    rst = 1;
    @(negedge clk);
    chk("reset_mid_burst", {busy, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                            bus.rready, refill_we, refresh}, 0);
    exp_r.delete(); exp_ref.delete(); exp_ar.delete();
    rst = 0; miss = 0;
    @(negedge clk);
    start_miss(rand_line(), rand_line(), 1'b1, 1'b0, 1'b0);
    wait_refresh(cyc, c1);
    miss = 0; write_back = 0;
    wait_idle();

    // back-to-back misses: second accepted on the first IDLE cycle
    start_miss(32'h0000_4040, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_refresh(cyc, c1);
    #1;
    start_miss(32'h0000_8080, 32'h0000_3080, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_idle_gap", busy, 0);
    @(negedge clk);
    chk("b2b_accept", {busy, bus.awvalid, bus.awaddr}, {1'b1, 1'b1, 32'h0000_3080});
    wait_refresh(cyc, c1);
    miss = 0; write_back = 0;
    wait_idle();

    // random back-pressure
    rand_bp = 1;
    for (int n = 0; n < 8; n++) begin
      start_miss(rand_line(), rand_line(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
      wait_refresh(cyc, c1);
      miss = 0; write_back = 0;
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_bp = 0;

    repeat (3) @(negedge clk);
    chk("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size()
                          + exp_ref.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
